// File: rtl/wb_master_bridge_pkg.sv
// Shared types and constants for the Wishbone classic initiator bridge.
// The state encoding is fixed so waveform viewers and future responders agree on it.
package wb_master_bridge_pkg;

    localparam int WB_SEL_WIDTH = 4;
    localparam int WB_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Writes and errors return zero data so the front end never sees stale bus contents.
    function automatic logic [WB_WORD_WIDTH-1:0] ack_data(
        input logic                     we,
        input logic [WB_WORD_WIDTH-1:0] dat
    );
        return we ? '0 : dat;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter that flags the last permitted cycle of a bus wait.
// LIMIT = 0 disables it entirely; expired is combinational on the registered count.
module wb_timeout_ctr #(
    parameter int LIMIT = 255,
    parameter int BITS  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit            RUN  = (LIMIT != 0);
    localparam logic [BITS-1:0] LAST = BITS'(LIMIT - 1);

    logic [BITS-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && RUN && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = RUN && enable && (count_reg == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator: valid/ready request in, one
// single-beat bus cycle out, registered response back with its own ack timeout.
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_BITS   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] req_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] req_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]  req_sel_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WB_DATA_WIDTH-1:0] rsp_dat_o,
    output logic                     rsp_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                     wb_ack_i
);

    state_t                   state_reg;
    logic                     req_ready_reg;
    logic                     rsp_valid_reg;
    logic                     rsp_err_reg;
    logic [WB_DATA_WIDTH-1:0] rsp_dat_reg;
    logic [WB_ADDR_WIDTH-1:0] wb_adr_reg;
    logic [WB_DATA_WIDTH-1:0] wb_dat_reg;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_reg;
    logic                     wb_we_reg;
    logic                     wb_cyc_reg;
    logic                     wb_stb_reg;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    // The counter is held at zero outside BUS, so it restarts on every accept.
    assign tmo_clear  = (state_reg != ST_BUS);
    assign tmo_enable = (state_reg == ST_BUS);

    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES),
        .BITS  (TIMEOUT_BITS)
    ) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_dat_reg   <= '0;
            wb_adr_reg    <= '0;
            wb_dat_reg    <= '0;
            wb_sel_reg    <= '0;
            wb_we_reg     <= 1'b0;
            wb_cyc_reg    <= 1'b0;
            wb_stb_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid_i && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        wb_adr_reg    <= req_adr_i;
                        wb_dat_reg    <= req_dat_i;
                        wb_sel_reg    <= req_sel_i;
                        wb_we_reg     <= req_we_i;
                        wb_cyc_reg    <= 1'b1;
                        wb_stb_reg    <= 1'b1;
                        state_reg     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so an ack on the expiry cycle still returns data.
                    if (wb_ack_i) begin
                        rsp_dat_reg   <= ack_data(wb_we_reg, wb_dat_i);
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        wb_cyc_reg    <= 1'b0;
                        wb_stb_reg    <= 1'b0;
                        wb_we_reg     <= 1'b0;
                        state_reg     <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_dat_reg   <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        wb_cyc_reg    <= 1'b0;
                        wb_stb_reg    <= 1'b0;
                        wb_we_reg     <= 1'b0;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b0;
                    wb_cyc_reg    <= 1'b0;
                    wb_stb_reg    <= 1'b0;
                    wb_we_reg     <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_err_o   = rsp_err_reg;
    assign rsp_dat_o   = rsp_dat_reg;
    assign wb_adr_o    = wb_adr_reg;
    assign wb_dat_o    = wb_dat_reg;
    assign wb_sel_o    = wb_sel_reg;
    assign wb_we_o     = wb_we_reg;
    assign wb_cyc_o    = wb_cyc_reg;
    assign wb_stb_o    = wb_stb_reg;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: a simple Wishbone slave model, a response monitor
// and a scoreboard of expected responses, exercised scenario by scenario.
module tb_wb_master_bridge;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat;
    logic [3:0]    req_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DW-1:0] slave_data = '0;
    int            slave_wait = -1;
    bit            late_arm   = 1'b0;
    logic          slave_ack  = 1'b0;
    logic          late_ack   = 1'b0;
    logic          prev_cyc   = 1'b0;
    int            slave_cnt  = 0;
    int            cyc_total  = 0;
    int            we_total   = 0;
    int            cycle_no   = 0;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_BITS   (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .req_sel_i   (req_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel),
        .wb_we_o     (wb_we),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack)
    );

    // Slave returns data derived from the address so each read is distinguishable.
    assign wb_ack   = slave_ack | late_ack;
    assign wb_dat_i = slave_data ^ wb_adr;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    always @(negedge clk) begin
        if (wb_cyc && wb_stb) begin
            slave_ack <= (slave_cnt == slave_wait);
            slave_cnt <= slave_cnt + 1;
            cyc_total <= cyc_total + 1;
            if (wb_we) we_total <= we_total + 1;
        end else begin
            slave_ack <= 1'b0;
            slave_cnt <= 0;
        end
        late_ack <= late_arm && prev_cyc && !wb_cyc;
        prev_cyc <= wb_cyc;
        if (rsp_valid && rsp_ready) obs_q.push_back({rsp_dat, rsp_err});
    end

    task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [3:0] sel, input string name);
        int guard = 0;
        req_we = we; req_adr = adr; req_dat = dat; req_sel = sel; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s_accept: req_ready_o=%b, required 1 within 50 cycles", name, req_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string name);
        rsp_t e;
        rsp_t o;
        int   guard = 0;
        while (obs_q.size() == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin
            $display("FAIL %s_rsp: no response within 50 cycles, required dat=%h err=%b", name, e.dat, e.err);
            n_fail++;
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                $display("FAIL %s_rsp: got dat=%h err=%b, required dat=%h err=%b", name, o.dat, o.err, e.dat, e.err);
                n_fail++;
            end else begin
                $display("txn %s: dat=%h err=%b", name, o.dat, o.err);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [105:0] snap;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        snap = {req_ready, rsp_valid, rsp_err, rsp_dat, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel};
        n_checks++;
        if (snap !== '0) begin
            $display("FAIL reset_outputs: got %h, required 0", snap);
            n_fail++;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready: req_ready_o=%b, required 1", req_ready);
            n_fail++;
        end
    endtask

    task automatic test_read();
        int c0;
        slave_wait = 2;
        slave_data = 32'hDEAD_BEEF ^ 32'h0010_0004;
        rsp_ready  = 1'b1;
        c0 = cyc_total;
        exp_q.push_back({32'hDEAD_BEEF, 1'b0});
        send(1'b0, 32'h0010_0004, 32'h0, 4'hF, "read");
        check_rsp("read");
        n_checks++;
        if (cyc_total - c0 !== 3) begin
            $display("FAIL read_cyc_cycles: got %0d, required 3", cyc_total - c0);
            n_fail++;
        end
        n_checks++;
        if (wb_adr !== 32'h0010_0004 || wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            $display("FAIL read_bus_after: adr=%h cyc=%b stb=%b, required adr=00100004 cyc=0 stb=0", wb_adr, wb_cyc, wb_stb);
            n_fail++;
        end
    endtask

    task automatic test_write();
        int c0;
        int w0;
        slave_wait = 0;
        slave_data = 32'hFFFF_FFFF;
        c0 = cyc_total;
        w0 = we_total;
        exp_q.push_back({32'h0, 1'b0});
        send(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, "write");
        check_rsp("write");
        n_checks++;
        if (we_total - w0 !== 1 || cyc_total - c0 !== 1) begin
            $display("FAIL write_we_bus: we cycles=%0d cyc cycles=%0d, required 1 and 1", we_total - w0, cyc_total - c0);
            n_fail++;
        end
        n_checks++;
        if (wb_dat_o !== 32'h1234_5678 || wb_sel !== 4'b0011 || wb_we !== 1'b0) begin
            $display("FAIL write_bus_after: dat=%h sel=%b we=%b, required 12345678 0011 0", wb_dat_o, wb_sel, wb_we);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        int c0;
        slave_wait = -1;
        late_arm   = 1'b1;
        c0 = cyc_total;
        exp_q.push_back({32'h0, 1'b1});
        send(1'b0, 32'h0000_0040, 32'h0, 4'hF, "timeout");
        check_rsp("timeout");
        late_arm = 1'b0;
        n_checks++;
        if (cyc_total - c0 !== TMO) begin
            $display("FAIL timeout_cyc_cycles: got %0d, required %0d", cyc_total - c0, TMO);
            n_fail++;
        end
        slave_wait = 1;
        slave_data = 32'h1357_9BDF;
        exp_q.push_back({32'h1357_9BDF ^ 32'h0000_0044, 1'b0});
        send(1'b0, 32'h0000_0044, 32'h0, 4'hF, "after_late_ack");
        check_rsp("after_late_ack");
    endtask

    task automatic test_backpressure();
        rsp_t held;
        int   guard = 0;
        rsp_ready  = 1'b0;
        slave_wait = 0;
        slave_data = 32'hCAFE_F00D ^ 32'h0000_0100;
        exp_q.push_back({32'hCAFE_F00D, 1'b0});
        send(1'b0, 32'h0000_0100, 32'h0, 4'hF, "bp_first");
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        held = {rsp_dat, rsp_err};
        n_checks++;
        if (rsp_valid !== 1'b1 || held !== {32'hCAFE_F00D, 1'b0}) begin
            $display("FAIL bp_first_data: valid=%b dat=%h err=%b, required 1 cafef00d 0", rsp_valid, held.dat, held.err);
            n_fail++;
        end
        @(posedge clk); #1;
        req_we = 1'b0; req_adr = 32'h0000_0104; req_dat = '0; req_sel = 4'hF; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || {rsp_dat, rsp_err} !== held || req_ready !== 1'b0 || wb_cyc !== 1'b0) begin
                $display("FAIL bp_stall_%0d: valid=%b dat=%h err=%b ready=%b cyc=%b, required 1 %h %b 0 0",
                         i, rsp_valid, rsp_dat, rsp_err, req_ready, wb_cyc, held.dat, held.err);
                n_fail++;
            end
        end
        @(posedge clk); #1;
        slave_data = 32'h2468_ACE0;
        exp_q.push_back({32'h2468_ACE0 ^ 32'h0000_0104, 1'b0});
        rsp_ready = 1'b1;
        send(1'b0, 32'h0000_0104, 32'h0, 4'hF, "bp_second");
        check_rsp("bp_first");
        check_rsp("bp_second");
    endtask

    task automatic test_reset_mid_bus();
        int r0;
        int v_seen = 0;
        slave_wait = -1;
        rsp_ready  = 1'b1;
        send(1'b0, 32'h0000_0200, 32'h0, 4'hF, "rst_mid");
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            $display("FAIL rst_mid_drop: cyc=%b stb=%b, required 0 0 before next edge", wb_cyc, wb_stb);
            n_fail++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r0 = obs_q.size();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) v_seen++;
        end
        n_checks++;
        if (req_ready !== 1'b1 || v_seen != 0 || obs_q.size() != r0) begin
            $display("FAIL rst_mid_after: ready=%b rsp_valid cycles=%0d, required ready=1 and 0 cycles", req_ready, v_seen);
            n_fail++;
        end else begin
            $display("txn rst_mid: abandoned, no response");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ack_at_expiry();
        int c0;
        slave_wait = TMO - 1;
        slave_data = 32'h0BAD_F00D ^ 32'h0000_0300;
        c0 = cyc_total;
        exp_q.push_back({32'h0BAD_F00D, 1'b0});
        send(1'b0, 32'h0000_0300, 32'h0, 4'hF, "ack_expiry");
        check_rsp("ack_expiry");
        n_checks++;
        if (cyc_total - c0 !== TMO) begin
            $display("FAIL ack_expiry_cyc_cycles: got %0d, required %0d", cyc_total - c0, TMO);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int stamps[3];
        int guard;
        rsp_ready  = 1'b1;
        slave_wait = 0;
        slave_data = 32'h5555_0000;
        for (int k = 0; k < 3; k++) begin
            req_we = 1'b0; req_adr = 32'h0000_0400 + 32'(4 * k); req_dat = '0; req_sel = 4'hF;
            req_valid = 1'b1;
            exp_q.push_back({32'h5555_0000 ^ (32'h0000_0400 + 32'(4 * k)), 1'b0});
            guard = 0;
            @(negedge clk);
            while (!req_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            stamps[k] = cycle_no;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) check_rsp($sformatf("b2b_%0d", k));
        n_checks++;
        if (stamps[1] - stamps[0] != 3 || stamps[2] - stamps[1] != 3) begin
            $display("FAIL b2b_spacing: got %0d and %0d cycles, required 3 and 3",
                     stamps[1] - stamps[0], stamps[2] - stamps[1]);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_ack_at_expiry();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 0) begin
            $display("FAIL stray_responses: %0d unexpected responses, required 0", obs_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
